// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load.
// A bit counter tracks shifts since the last load/reset and pulses word_valid
// for one cycle each time WIDTH shifts have completed a word.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    ModeHold  = 2'b00,
    ModeShr   = 2'b01,
    ModeShl   = 2'b10,
    ModeLoad  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;

  logic [WIDTH-1:0] w_data_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_valid_nxt;
  logic             w_shift;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  // Next-state: data path per mode, then shift counting with word wrap.
  always_comb begin
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_shift     = 1'b0;
    if (en) begin
      unique case (w_mode)
        ModeHold: ;
        ModeShr: begin
          w_data_nxt = {ser_in, r_data[WIDTH-1:1]};
          w_shift    = 1'b1;
        end
        ModeShl: begin
          w_data_nxt = {r_data[WIDTH-2:0], ser_in};
          w_shift    = 1'b1;
        end
        ModeLoad: begin
          w_data_nxt = par_in;
          w_cnt_nxt  = '0;
        end
        default: ;
      endcase
    end
    // Direction changes do not matter: every shift edge counts toward the word.
    if (w_shift) begin
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Serial out presents the bit that the current mode would shift out.
  always_comb begin
    ser_out = (w_mode == ModeShr) ? r_data[0] : r_data[WIDTH-1];
  end

  assign par_out    = r_data;
  assign bit_cnt    = r_cnt;
  assign word_valid = r_valid;

endmodule

// File: tb/tb_universal_shift_reg.sv
`timescale 1ps/1ps
module tb_universal_shift_reg;

  logic        clk;
  logic        reset;
  // 32-bit instance
  logic        en;
  logic [1:0]  mode;
  logic        ser_in;
  logic [31:0] par_in;
  logic [31:0] par_out;
  logic        ser_out;
  logic        word_valid;
  logic [4:0]  bit_cnt;
  // 8-bit instance
  logic        en8;
  logic [1:0]  mode8;
  logic        ser8;
  logic [7:0]  par8;
  logic [7:0]  par_out8;
  logic        ser_out8;
  logic        valid8;
  logic [2:0]  cnt8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: value plus count of shifts since last load/reset.
  logic [31:0] m_val;
  int          m_shifts;
  logic        m_valid;

  universal_shift_reg #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in), .par_in(par_in),
    .par_out(par_out), .ser_out(ser_out), .word_valid(word_valid), .bit_cnt(bit_cnt)
  );

  universal_shift_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .mode(mode8), .ser_in(ser8), .par_in(par8),
    .par_out(par_out8), .ser_out(ser_out8), .word_valid(valid8), .bit_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_val    = '0;
    m_shifts = 0;
    m_valid  = 1'b0;
  endtask

  task automatic model_edge();
    m_valid = 1'b0;
    if (en) begin
      if (mode == 2'b11) begin
        m_val    = par_in;
        m_shifts = 0;
      end else if (mode == 2'b01 || mode == 2'b10) begin
        if (mode == 2'b01) m_val = (m_val >> 1) | ({31'b0, ser_in} << 31);
        else               m_val = (m_val << 1) | {31'b0, ser_in};
        m_shifts = m_shifts + 1;
        if (m_shifts % 32 == 0) m_valid = 1'b1;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; mode = 2'b11; par_in = '1; ser_in = 1'b1;
    en8 = 1'b0; mode8 = 2'b00; ser8 = 1'b0; par8 = '0;
    #18;
    n_checks++;
    if (par_out !== 32'h0 || bit_cnt !== 5'd0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: par_out=%h bit_cnt=%0d wv=%b, required 0/0/0",
               par_out, bit_cnt, word_valid);
    end
    #2 reset = 1'b1;
    model_reset();
    par_in = 32'hFFFF_FFFA;
    #1;
    n_checks++;
    if (par_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_no_edge: par_out=%h required 00000000", par_out);
    end
    tick();
    n_checks++;
    if (par_out !== 32'hFFFF_FFFA || bit_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL load1: par_out=%h bit_cnt=%0d required fffffffa/0", par_out, bit_cnt);
    end
    par_in = 32'hBBAF_FFFF;
    tick();
    n_checks++;
    if (par_out !== 32'hBBAF_FFFF || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load2: par_out=%h wv=%b required bbafffff/0", par_out, word_valid);
    end
  endtask

  task automatic test_shift_right_word();
    logic [31:0] pat;
    pat = 32'hA5A5_A5A5;
    en = 1'b1; mode = 2'b11; par_in = $urandom;
    tick();
    mode = 2'b01;
    for (int i = 0; i < 32; i++) begin
      ser_in = pat[i];
      par_in = $urandom;
      tick();
      n_checks++;
      if (word_valid !== (i == 31)) begin
        n_fail++;
        $display("FAIL shr_valid[%0d]: wv=%b required %b", i, word_valid, (i == 31));
      end
    end
    n_checks++;
    if (par_out !== 32'hA5A5_A5A5 || bit_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL shr_word: par_out=%h bit_cnt=%0d required a5a5a5a5/0", par_out, bit_cnt);
    end
    mode = 2'b00;
    tick();
    n_checks++;
    if (word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL shr_pulse_width: wv=%b required 0", word_valid);
    end
  endtask

  task automatic test_shift_left8();
    logic [7:0] exp_seq;
    exp_seq = 8'h81;
    en = 1'b0;
    en8 = 1'b1; mode8 = 2'b11; par8 = 8'h81;
    @(posedge clk); #1;
    n_checks++;
    if (par_out8 !== 8'h81 || cnt8 !== 3'd0) begin
      n_fail++;
      $display("FAIL shl8_load: par_out=%h cnt=%0d required 81/0", par_out8, cnt8);
    end
    mode8 = 2'b10; ser8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (ser_out8 !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL shl8_ser_out[%0d]: got %b required %b", i, ser_out8, exp_seq[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (valid8 !== (i == 7)) begin
        n_fail++;
        $display("FAIL shl8_valid[%0d]: wv=%b required %b", i, valid8, (i == 7));
      end
    end
    n_checks++;
    if (par_out8 !== 8'h00 || cnt8 !== 3'd0) begin
      n_fail++;
      $display("FAIL shl8_final: par_out=%h cnt=%0d required 00/0", par_out8, cnt8);
    end
    en8 = 1'b0;
    // Re-sync the 32-bit model with a load.
    en = 1'b1; mode = 2'b11; par_in = $urandom;
    tick();
  endtask

  task automatic test_mid_reset();
    en = 1'b1; mode = 2'b11; par_in = $urandom;
    tick();
    for (int i = 0; i < 5; i++) begin
      mode = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      ser_in = 1'($urandom);
      tick();
    end
    n_checks++;
    if (bit_cnt !== 5'd5 || par_out !== m_val) begin
      n_fail++;
      $display("FAIL mid_reset_pre: bit_cnt=%0d par_out=%h required 5/%h",
               bit_cnt, par_out, m_val);
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (par_out !== 32'h0 || bit_cnt !== 5'd0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: par_out=%h bit_cnt=%0d wv=%b required 0/0/0",
               par_out, bit_cnt, word_valid);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mode = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      ser_in = 1'($urandom);
      tick();
      n_checks++;
      if (word_valid !== (i == 31) || bit_cnt !== 5'((i + 1) % 32) || par_out !== m_val) begin
        n_fail++;
        $display("FAIL mid_reset_shift[%0d]: wv=%b cnt=%0d par=%h required %b/%0d/%h",
                 i, word_valid, bit_cnt, par_out, (i == 31), (i + 1) % 32, m_val);
      end
    end
  endtask

  task automatic test_pause();
    logic [31:0] held;
    en = 1'b1; mode = 2'b11; par_in = $urandom;
    tick();
    for (int i = 0; i < 10; i++) begin
      mode = 2'b01; ser_in = 1'($urandom);
      tick();
    end
    held = m_val;
    for (int i = 0; i < 5; i++) begin
      en = (i < 3) ? 1'b0 : 1'b1;
      mode = (i < 3) ? 2'($urandom) : 2'b00;
      ser_in = 1'($urandom); par_in = $urandom;
      tick();
      n_checks++;
      if (par_out !== held || bit_cnt !== 5'd10 || word_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL pause[%0d]: par=%h cnt=%0d wv=%b required %h/10/0",
                 i, par_out, bit_cnt, word_valid, held);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      mode = 2'b10; ser_in = 1'($urandom);
      tick();
      n_checks++;
      if (word_valid !== (i == 21)) begin
        n_fail++;
        $display("FAIL pause_resume[%0d]: wv=%b required %b", i, word_valid, (i == 21));
      end
    end
  endtask

  task automatic test_load_abort();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mode = 2'b01; ser_in = 1'($urandom);
      tick();
    end
    mode = 2'b11; par_in = 32'h1234_5678;
    tick();
    n_checks++;
    if (par_out !== 32'h1234_5678 || bit_cnt !== 5'd0 || word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_abort: par=%h cnt=%0d wv=%b required 12345678/0/0",
               par_out, bit_cnt, word_valid);
    end
    // Two back-to-back words: pulses exactly at shift 32 and 64.
    for (int i = 0; i < 64; i++) begin
      mode = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      ser_in = 1'($urandom);
      tick();
      n_checks++;
      if (word_valid !== (i == 31 || i == 63)) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: wv=%b required %b", i, word_valid,
                 (i == 31 || i == 63));
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 31);
      if (r == 0)      mode = 2'b11;
      else if (r < 3)  mode = 2'b00;
      else             mode = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      ser_in = 1'($urandom);
      par_in = $urandom;
      tick();
      n_checks++;
      if (par_out !== m_val || bit_cnt !== 5'(m_shifts % 32) || word_valid !== m_valid ||
          ser_out !== ((mode == 2'b01) ? m_val[0] : m_val[31])) begin
        n_fail++;
        $display("FAIL random[%0d]: par=%h cnt=%0d wv=%b so=%b required %h/%0d/%b/%b",
                 i, par_out, bit_cnt, word_valid, ser_out, m_val, m_shifts % 32, m_valid,
                 (mode == 2'b01) ? m_val[0] : m_val[31]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_right_word();
    test_shift_left8();
    test_mid_reset();
    test_pause();
    test_load_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
